alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter SIZE, default 32: data width of operands, result and I/O buses.
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data holds a valid beat.
REQ-006 in_ready  output  1  controller accepts a beat this cycle.
REQ-007 in_data  input  SIZE  beat payload: operand A, then operand B, then OP in bits [3:0].
REQ-008 abort  input  1  discard the current operation and return to IDLE.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_data  output  SIZE  beat 1 is ALU result F; beat 2 is {zeros, ZF, CF, OF, SF, PF}.
REQ-012 out_last  output  1  high with beat 2 only.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 op_cnt  output  CNT_W  count of operations whose flag beat was accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, GET_B, GET_OP, EXEC, OUT_F and OUT_FLAGS.
REQ-016 A transfer SHALL occur on a cycle where valid and ready are both high; it SHALL not occur otherwise.
REQ-017 in_ready SHALL be high in IDLE, GET_B and GET_OP, and low in EXEC, OUT_F and OUT_FLAGS.
REQ-018 Operand A SHALL be registered on the IDLE transfer (next state GET_B), B on the GET_B transfer (next state GET_OP), and OP from in_data[3:0] on the GET_OP transfer (next state EXEC).
REQ-019 EXEC SHALL last exactly one cycle: it registers ALU F and the five flags from the registered A, B and OP, then moves to OUT_F.
REQ-020 Latency from the OP transfer to the first cycle of out_valid SHALL be 2 cycles.
REQ-021 In OUT_F, out_valid=1, out_data=F_reg and out_last=0; on transfer the FSM moves to OUT_FLAGS.
REQ-022 In OUT_FLAGS, out_valid=1, out_data={(SIZE-5)'b0, ZF, CF, OF, SF, PF} and out_last=1; on transfer the FSM moves to IDLE and increments op_cnt.
REQ-023 While out_ready=0, out_data and out_last SHALL hold stable.
REQ-024 out_valid SHALL be 0 in IDLE, GET_B, GET_OP and EXEC.
REQ-025 op_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturating.
REQ-026 abort SHALL return the FSM to IDLE on the next edge from any state, with no transfer and no op_cnt increment; input and output transfers in that cycle are ignored.
REQ-027 Operand, OP and result registers SHALL not change outside their load cycles.
REQ-028 All 16 OP codes SHALL be forwarded to the ALU unchanged; the ALU defines their meaning.

Reset
REQ-029 While rst=1: state=IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, op_cnt=0, out_data=0, and the A, B, OP, F and flag registers=0.
REQ-030 rst SHALL take priority over abort and over every handshake; a rst in the middle of an operation discards it.
REQ-031 in_ready SHALL assert in the first cycle after rst deasserts.

Structure
REQ-032 The shared package alu_pkg SHALL hold the state enumeration, the OP code constants (OP_ADD, OP_SUB, …) and the flag bit positions within beat 2.
REQ-033 The existing combinational ALU SHALL be instantiated as the single sub-module, with ports OP, A, B, F, ZF, CF, OF, SF and PF.
REQ-034 Outputs SHALL be driven from registers and the state decode only; there SHALL be no combinational path from in_data to out_data.

Verification
REQ-035 Basic add: A=5, B=3, OP=OP_ADD with out_ready=1 -> out_data=8 then flag beat with ZF=0; out_last on beat 2 only; op_cnt=1.
REQ-036 Zero/carry case: A=32'hFFFFFFFF, B=1, OP=OP_ADD -> F=0, ZF=1, CF=1 in the flag beat.
REQ-037 Backpressure: out_ready=0 for 5 cycles in OUT_F -> out_data held at F with in_ready=0; completes normally once out_ready=1.
REQ-038 Abort: abort=1 in GET_OP -> IDLE next cycle, no output beats, op_cnt unchanged; a following full operation is correct.
REQ-039 Reset mid-operation: rst=1 in OUT_FLAGS -> all outputs at reset values, op_cnt=0.
REQ-040 Wrap: preload op_cnt=16'hFFFF through 65535 operations (or with the counter forced) -> next completed operation gives op_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencing controller:
// FSM states, ALU op codes and flag bit positions within the flag beat.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        OUT_F,
        OUT_FLAGS
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_INC   = 4'd8;
    localparam logic [3:0] OP_DEC   = 4'd9;
    localparam logic [3:0] OP_PASSA = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_NAND  = 4'd12;
    localparam logic [3:0] OP_NOR   = 4'd13;
    localparam logic [3:0] OP_XNOR  = 4'd14;
    localparam logic [3:0] OP_SAR   = 4'd15;

    localparam int FLAG_W  = 5;
    localparam int FLAG_PF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_CF = 3;
    localparam int FLAG_ZF = 4;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Valid/ready input and output streams of the ALU sequencing controller.
interface alu_seq_ctrl_if #(parameter int SIZE = 32) ();
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic            out_last;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational ALU: 16 ops on A/B producing F plus zero, carry/borrow,
// signed-overflow, sign and even-parity flags.
module alu_seq_ctrl_alu
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [3:0]      OP,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic [SIZE-1:0] F,
    output logic            ZF,
    output logic            CF,
    output logic            OF,
    output logic            SF,
    output logic            PF
);
    localparam int MSB = SIZE - 1;

    logic [SIZE:0] wide;

    always_comb begin
        wide = '0;
        F    = '0;
        CF   = 1'b0;
        OF   = 1'b0;
        case (OP)
            OP_ADD: begin
                wide = {1'b0, A} + {1'b0, B};
                F    = wide[MSB:0];
                CF   = wide[SIZE];
                OF   = (A[MSB] == B[MSB]) && (F[MSB] != A[MSB]);
            end
            OP_SUB: begin
                // CF reports a borrow, i.e. A < B unsigned
                wide = {1'b0, A} - {1'b0, B};
                F    = wide[MSB:0];
                CF   = wide[SIZE];
                OF   = (A[MSB] != B[MSB]) && (F[MSB] != A[MSB]);
            end
            OP_INC: begin
                wide = {1'b0, A} + (SIZE+1)'(1);
                F    = wide[MSB:0];
                CF   = wide[SIZE];
                OF   = !A[MSB] && F[MSB];
            end
            OP_DEC: begin
                wide = {1'b0, A} - (SIZE+1)'(1);
                F    = wide[MSB:0];
                CF   = wide[SIZE];
                OF   = A[MSB] && !F[MSB];
            end
            OP_SHL:   begin F = {A[MSB-1:0], 1'b0}; CF = A[MSB]; end
            OP_SHR:   begin F = {1'b0, A[MSB:1]};   CF = A[0];   end
            OP_SAR:   begin F = {A[MSB], A[MSB:1]}; CF = A[0];   end
            OP_AND:   F = A & B;
            OP_OR:    F = A | B;
            OP_XOR:   F = A ^ B;
            OP_NOT:   F = ~A;
            OP_PASSA: F = A;
            OP_PASSB: F = B;
            OP_NAND:  F = ~(A & B);
            OP_NOR:   F = ~(A | B);
            OP_XNOR:  F = ~(A ^ B);
            default:  F = '0;
        endcase
        ZF = (F == '0);
        SF = F[MSB];
        PF = ~^F;
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Collects A, B and OP as three input beats, runs one ALU op, then emits
// the result beat and a flag beat (out_last) and counts completed ops.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_ctrl_if.slave    bus,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);
    state_t              state, state_nxt;
    logic [SIZE-1:0]     a_q, b_q, f_q;
    logic [3:0]          op_q;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [SIZE-1:0]     alu_f;
    logic                zf, cf, of, sf, pf;
    logic                live, in_xfer, out_xfer;

    alu_seq_ctrl_alu #(.SIZE(SIZE)) u_alu (
        .OP(op_q), .A(a_q), .B(b_q), .F(alu_f),
        .ZF(zf), .CF(cf), .OF(of), .SF(sf), .PF(pf)
    );

    // rst gates the handshake outputs so they read idle for the whole reset
    assign live          = !rst;
    assign bus.in_ready  = live && (state == IDLE || state == GET_B || state == GET_OP);
    assign bus.out_valid = live && (state == OUT_F || state == OUT_FLAGS);
    assign bus.out_last  = live && (state == OUT_FLAGS);
    assign busy          = live && (state != IDLE);
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = bus.out_valid && bus.out_ready;

    always_comb begin
        bus.out_data = '0;
        if (live && state == OUT_F)
            bus.out_data = f_q;
        else if (live && state == OUT_FLAGS)
            bus.out_data = SIZE'(flags_q);
    end

    always_comb begin
        flags_d          = '0;
        flags_d[FLAG_ZF] = zf;
        flags_d[FLAG_CF] = cf;
        flags_d[FLAG_OF] = of;
        flags_d[FLAG_SF] = sf;
        flags_d[FLAG_PF] = pf;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (in_xfer)  state_nxt = GET_B;
            GET_B:     if (in_xfer)  state_nxt = GET_OP;
            GET_OP:    if (in_xfer)  state_nxt = EXEC;
            EXEC:                    state_nxt = OUT_F;
            OUT_F:     if (out_xfer) state_nxt = OUT_FLAGS;
            OUT_FLAGS: if (out_xfer) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            f_q     <= '0;
            flags_q <= '0;
            op_cnt  <= '0;
        end else if (!abort) begin
            case (state)
                IDLE:      if (in_xfer) a_q  <= bus.in_data;
                GET_B:     if (in_xfer) b_q  <= bus.in_data;
                GET_OP:    if (in_xfer) op_q <= bus.in_data[3:0];
                EXEC: begin
                    f_q     <= alu_f;
                    flags_q <= flags_d;
                end
                OUT_FLAGS: if (out_xfer) op_cnt <= op_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: transaction-level model checked every
// cycle, plus hand-computed literal results for key operations.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;
    localparam longint TWO32 = 64'h1_0000_0000;
    localparam longint MAXS  = 64'h0000_0000_7FFF_FFFF;
    localparam longint MINS  = -64'sh0000_0000_8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    alu_seq_ctrl_if #(.SIZE(SIZE)) bus ();

    alu_seq_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .abort(abort), .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Returns {ZF,CF,OF,SF,PF,F} using plain integer arithmetic.
    function automatic logic [36:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        logic [31:0] f = '0;
        bit c = 0, o = 0, z, s, p;
        case (op)
            OP_ADD:   begin r = ua + ub; f = r[31:0]; c = (r >= TWO32); r = sa + sb; o = (r > MAXS) || (r < MINS); end
            OP_SUB:   begin r = ua - ub; f = r[31:0]; c = (ua < ub);    r = sa - sb; o = (r > MAXS) || (r < MINS); end
            OP_INC:   begin r = ua + 1;  f = r[31:0]; c = (r >= TWO32); o = (sa + 1 > MAXS); end
            OP_DEC:   begin r = ua - 1;  f = r[31:0]; c = (ua == 0);    o = (sa - 1 < MINS); end
            OP_SHL:   begin r = ua * 2;  f = r[31:0]; c = (r >= TWO32); end
            OP_SHR:   begin r = ua / 2;  f = r[31:0]; c = (ua % 2) != 0; end
            OP_SAR:   begin r = (sa - (ua % 2)) / 2; f = r[31:0]; c = (ua % 2) != 0; end
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_NOT:   f = ~a;
            OP_PASSA: f = a;
            OP_PASSB: f = b;
            OP_NAND:  f = ~(a & b);
            OP_NOR:   f = ~(a | b);
            default:  f = ~(a ^ b);
        endcase
        z = (f == 0);
        s = (longint'(f) >= 64'h8000_0000);
        p = ($countones(f) % 2) == 0;
        return {z, c, o, s, p, f};
    endfunction

    // Transaction model: beats collected, one exec cycle, then queued output beats.
    int          m_nin  = 0;
    bit          m_exec = 0;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [31:0] m_beats[$];
    int          m_cnt  = 0;
    bit          armed  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_nin = 0; m_exec = 0; m_beats.delete(); m_cnt = 0; armed = 1;
        end else if (armed) begin
            if (abort) begin
                m_nin = 0; m_exec = 0; m_beats.delete();
            end else if (m_exec) begin
                logic [36:0] res;
                res = model_alu(m_op, m_a, m_b);
                m_beats.push_back(res[31:0]);
                m_beats.push_back({27'b0, res[36:32]});
                m_exec = 0; m_nin = 0;
            end else if (m_beats.size() > 0) begin
                if (bus.out_ready) begin
                    void'(m_beats.pop_front());
                    if (m_beats.size() == 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end
            end else if (bus.in_valid) begin
                case (m_nin)
                    0:       m_a  = bus.in_data;
                    1:       m_b  = bus.in_data;
                    default: m_op = bus.in_data[3:0];
                endcase
                m_nin++;
                if (m_nin == 3) m_exec = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit er, ev, eb;
            er = !rst && !m_exec && m_nin < 3 && m_beats.size() == 0;
            ev = !rst && m_beats.size() > 0;
            eb = !rst && (m_nin > 0 || m_exec || m_beats.size() > 0);
            check("in_ready", bus.in_ready, er);
            check("out_valid", bus.out_valid, ev);
            check("busy", busy, eb);
            check("op_cnt", op_cnt, m_cnt);
            if (ev) begin
                check("out_data", bus.out_data, m_beats[0]);
                check("out_last", bus.out_last, m_beats.size() == 1);
            end else begin
                check("out_last_idle", bus.out_last, 0);
                if (rst) check("out_data_rst", bus.out_data, 0);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        check("send_done", done, 1);
    endtask

    task automatic recv_beat(output logic [31:0] d, output logic l);
        bit done = 0;
        d = '0; l = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                d = bus.out_data; l = bus.out_last;
                @(posedge clk); #1;
                done = 1;
            end
        end
        check("recv_done", done, 1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          output logic [31:0] f, output logic [31:0] fl);
        logic l1, l2;
        send_beat(a); send_beat(b); send_beat({28'b0, op});
        recv_beat(f, l1);
        recv_beat(fl, l2);
        check("last_on_beat1", l1, 0);
        check("last_on_beat2", l2, 1);
    endtask

    initial begin
        logic [31:0] f, fl;
        logic        l;
        logic [31:0] pa[2] = '{32'h1234_5678, 32'h8000_0000};
        logic [31:0] pb[2] = '{32'h0F0F_00FF, 32'hFFFF_FFFF};
        bit          seen;

        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_cnt", op_cnt, 0);
        check("rst_out_data", bus.out_data, 0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        @(posedge clk); #1;

        // basic add
        run_op(32'd5, 32'd3, OP_ADD, f, fl);
        check("add_f", f, 8);
        check("add_flags", fl, 0);
        check("add_cnt", op_cnt, 1);

        // zero + carry
        run_op(32'hFFFF_FFFF, 32'd1, OP_ADD, f, fl);
        check("wrap_f", f, 0);
        check("wrap_flags", fl, 32'h19);
        check("wrap_cnt", op_cnt, 2);

        // backpressure on result beat
        bus.out_ready = 0;
        send_beat(32'd7); send_beat(32'd2); send_beat({28'b0, OP_SUB});
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.out_valid === 1'b1);
        end
        check("bp_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_data", bus.out_data, 5);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        recv_beat(f, l);
        check("bp_f", f, 5);
        recv_beat(fl, l);
        check("bp_flags", fl, 32'h01);
        check("bp_cnt", op_cnt, 3);

        // abort in GET_OP, with an input beat offered in the same cycle
        send_beat(32'd9); send_beat(32'd4);
        abort = 1; bus.in_valid = 1; bus.in_data = {28'b0, OP_ADD};
        @(posedge clk); #1;
        abort = 0; bus.in_valid = 0;
        check("abort_busy", busy, 0);
        check("abort_cnt", op_cnt, 3);
        repeat (3) @(posedge clk);
        #1;
        run_op(32'd10, 32'd3, OP_SUB, f, fl);
        check("post_abort_f", f, 7);
        check("post_abort_flags", fl, 0);
        check("post_abort_cnt", op_cnt, 4);

        // all 16 op codes, checked against the model every cycle
        for (int op = 0; op < 16; op++)
            for (int p = 0; p < 2; p++)
                run_op(pa[p], pb[p], 4'(op), f, fl);

        // literal results that pin both the DUT and the model
        run_op(32'h8000_0001, 32'd0, OP_SHL, f, fl);
        check("shl_f", f, 2);          check("shl_flags", fl, 32'h08);
        check("model_shl", model_alu(OP_SHL, 32'h8000_0001, 0), {5'h08, 32'd2});
        run_op(32'd0, 32'd0, OP_DEC, f, fl);
        check("dec_f", f, 32'hFFFF_FFFF); check("dec_flags", fl, 32'h0B);
        check("model_dec", model_alu(OP_DEC, 0, 0), {5'h0B, 32'hFFFF_FFFF});
        run_op(32'h7FFF_FFFF, 32'd0, OP_INC, f, fl);
        check("inc_f", f, 32'h8000_0000); check("inc_flags", fl, 32'h06);
        check("model_inc", model_alu(OP_INC, 32'h7FFF_FFFF, 0), {5'h06, 32'h8000_0000});
        run_op(32'h8000_0003, 32'd0, OP_SAR, f, fl);
        check("sar_f", f, 32'hC000_0001); check("sar_flags", fl, 32'h0A);
        check("model_sar", model_alu(OP_SAR, 32'h8000_0003, 0), {5'h0A, 32'hC000_0001});

        // reset while the flag beat is waiting
        send_beat(32'd1); send_beat(32'd2); send_beat({28'b0, OP_ADD});
        recv_beat(f, l);
        bus.out_ready = 0;
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_last", bus.out_last, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", op_cnt, 0);
        check("midrst_out_data", bus.out_data, 0);
        @(posedge clk); #1; rst = 0; bus.out_ready = 1;
        @(negedge clk);
        check("midrst_ready_after", bus.in_ready, 1);
        @(posedge clk); #1;

        // counter wrap at 2^CNT_W-1
        for (int i = 0; i < (1 << CNT_W) - 1; i++)
            run_op(32'(i), 32'(i), OP_ADD, f, fl);
        check("cnt_max", op_cnt, (1 << CNT_W) - 1);
        run_op(32'd1, 32'd1, OP_ADD, f, fl);
        check("cnt_wrap", op_cnt, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
